mastermind_scorer: RTL

Scores a 4-peg Mastermind guess against the secret code. It produces the exact-match count (right colour, right place) and the colour-match count (right colour, wrong place). Both are 3-bit codes that drive the sideHEXDisplay numDisplay inputs directly, so this block is the producer side of that display interface. It runs as a multi-cycle FSM started by a one-cycle pulse from the game controller.

---
 rtl/mastermind_pkg.sv | 26 ++
 rtl/mastermind_scorer_if.sv | 25 ++
 rtl/mastermind_scorer_peg_color_counter.sv | 16 +
 rtl/mastermind_scorer.sv | 109 ++++++++++
 4 files changed

// File: rtl/mastermind_pkg.sv
// Shared types and helpers for the Mastermind scorer: code packing, peg access and FSM states.
package mastermind_pkg;
  localparam int NUM_PEGS = 4;
  localparam int COLOR_W  = 3;

  typedef logic [COLOR_W-1:0]          peg_t;
  typedef logic [NUM_PEGS*COLOR_W-1:0] code_t;

  // Display code for a blank digit
  localparam logic [2:0] COUNT_OFF = 3'b111;

  typedef enum logic [1:0] {IDLE, EXACT, COLOR} scorer_state_t;

  function automatic peg_t peg_at(input code_t c, input logic [1:0] p);
    case (p)
      2'd0:    return c[2:0];
      2'd1:    return c[5:3];
      2'd2:    return c[8:6];
      default: return c[11:9];
    endcase
  endfunction

  function automatic logic [2:0] min3(input logic [2:0] a, input logic [2:0] b);
    return (a < b) ? a : b;
  endfunction
endpackage

// File: rtl/mastermind_scorer_if.sv
// Controller <-> scorer bus. The optional win flag exists only when SCORER_WIN_EN is defined.
interface mastermind_scorer_if;
  import mastermind_pkg::*;

  logic       start;
  code_t      secret;
  code_t      guess;
  logic [2:0] exactCount;
  logic [2:0] colorCount;
  logic       busy;
  logic       done;
`ifdef SCORER_WIN_EN
  logic       win;

  modport master (output start, secret, guess,
                  input  exactCount, colorCount, busy, done, win);
  modport slave  (input  start, secret, guess,
                  output exactCount, colorCount, busy, done, win);
`else
  modport master (output start, secret, guess,
                  input  exactCount, colorCount, busy, done);
  modport slave  (input  start, secret, guess,
                  output exactCount, colorCount, busy, done);
`endif
endinterface

// File: rtl/mastermind_scorer_peg_color_counter.sv
// Combinational count of unmasked pegs in a code that carry a given colour.
module peg_color_counter
  import mastermind_pkg::*;
(
  input  code_t               i_code,
  input  logic [NUM_PEGS-1:0] i_mask,
  input  peg_t                i_color,
  output logic [2:0]          o_count
);
  always_comb begin
    o_count = '0;
    for (int p = 0; p < NUM_PEGS; p++)
      if (!i_mask[p] && (i_code[p*COLOR_W +: COLOR_W] == i_color))
        o_count = o_count + 3'd1;
  end
endmodule

// File: rtl/mastermind_scorer.sv
// Multi-cycle Mastermind scorer: one peg per cycle for exact hits, then one colour per cycle.
// Optional feature macro: SCORER_WIN_EN adds a sticky win flag on the bus.
module mastermind_scorer
  import mastermind_pkg::*;
#(
  parameter int NUM_COLORS = 6
) (
  input  logic                clk,
  input  logic                Reset,
  mastermind_scorer_if.slave  bus
);
  scorer_state_t       r_state, w_next;
  code_t               r_secret, r_guess;
  logic [NUM_PEGS-1:0] r_smask, r_gmask;
  logic [1:0]          r_pos;
  peg_t                r_col;
  logic [2:0]          r_eacc, r_cacc;
  logic [2:0]          r_exact, r_color;
  logic                r_done;
  logic [2:0]          w_s_cnt, w_g_cnt, w_min;
  logic                w_peg_eq, w_last_col;

  assign w_peg_eq   = (peg_at(r_secret, r_pos) == peg_at(r_guess, r_pos));
  assign w_last_col = (r_col == peg_t'(NUM_COLORS - 1));
  assign w_min      = min3(w_s_cnt, w_g_cnt);

  peg_color_counter u_sec_cnt (.i_code(r_secret), .i_mask(r_smask), .i_color(r_col), .o_count(w_s_cnt));
  peg_color_counter u_gss_cnt (.i_code(r_guess),  .i_mask(r_gmask), .i_color(r_col), .o_count(w_g_cnt));

  always_ff @(posedge clk) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = EXACT;
      EXACT:   if (r_pos == 2'd3) w_next = COLOR;
      COLOR:   if (w_last_col) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_secret <= '0;
      r_guess  <= '0;
      r_smask  <= '0;
      r_gmask  <= '0;
      r_pos    <= '0;
      r_col    <= '0;
      r_eacc   <= '0;
      r_cacc   <= '0;
      r_exact  <= COUNT_OFF;
      r_color  <= COUNT_OFF;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (bus.start) begin
          r_secret <= bus.secret;
          r_guess  <= bus.guess;
          r_smask  <= '0;
          r_gmask  <= '0;
          r_pos    <= '0;
          r_col    <= '0;
          r_eacc   <= '0;
          r_cacc   <= '0;
        end
        EXACT: begin
          // Matched pegs are masked so the colour pass cannot count them twice
          if (w_peg_eq) begin
            r_eacc         <= r_eacc + 3'd1;
            r_smask[r_pos] <= 1'b1;
            r_gmask[r_pos] <= 1'b1;
          end
          r_pos <= r_pos + 2'd1;
          if (r_pos == 2'd3) r_col <= '0;
        end
        COLOR: begin
          r_cacc <= r_cacc + w_min;
          r_col  <= r_col + 3'd1;
          if (w_last_col) begin
            r_exact <= r_eacc;
            r_color <= r_cacc + w_min;
            r_done  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.exactCount = r_exact;
  assign bus.colorCount = r_color;
  assign bus.busy       = (r_state != IDLE);
  assign bus.done       = r_done;

`ifdef SCORER_WIN_EN
  logic r_win;
  always_ff @(posedge clk) begin
    if (Reset)                                   r_win <= 1'b0;
    else if (r_state == IDLE && bus.start)       r_win <= 1'b0;
    else if (r_state == COLOR && w_last_col)     r_win <= (r_eacc == 3'd4);
  end
  assign bus.win = r_win;
`endif
endmodule
